// File: rtl/mc_pkg.sv
// Shared constants and instruction-field helpers for the multicycle CPU.
package mc_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam logic [4:0]  REG_RA    = 5'd31;

  // Opcodes used by the control unit and by directed programs.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // ALUOp encodings.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  // PCSrc encodings.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // ExtSel encodings (11 behaves as sign-extend).
  localparam logic [1:0] EXT_SA   = 2'b00;
  localparam logic [1:0] EXT_ZIMM = 2'b01;
  localparam logic [1:0] EXT_SIMM = 2'b10;

  // RegOut encodings (11 behaves as rd).
  localparam logic [1:0] REGOUT_RA = 2'b00;
  localparam logic [1:0] REGOUT_RT = 2'b01;
  localparam logic [1:0] REGOUT_RD = 2'b10;

  function automatic logic [5:0]  f_op (input logic [31:0] ir); return ir[31:26]; endfunction
  function automatic logic [4:0]  f_rs (input logic [31:0] ir); return ir[25:21]; endfunction
  function automatic logic [4:0]  f_rt (input logic [31:0] ir); return ir[20:16]; endfunction
  function automatic logic [4:0]  f_rd (input logic [31:0] ir); return ir[15:11]; endfunction
  function automatic logic [4:0]  f_sa (input logic [31:0] ir); return ir[10:6];  endfunction
  function automatic logic [15:0] f_imm(input logic [31:0] ir); return ir[15:0];  endfunction
  function automatic logic [25:0] f_tgt(input logic [31:0] ir); return ir[25:0];  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file: two combinational read ports, one write port,
// r0 hardwired to zero, synchronous active-high reset.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            we,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [REG_COUNT];

  // Register array update; reset clears every entry, writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports return the pre-edge contents; no write bypass.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle CPU datapath: PC, IR, register file, extender, ALU and the
// inter-stage latches, steered each cycle by the control unit's bus.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            PCWre,
  input  logic            IRWre,
  input  logic            RegWre,
  input  logic            ALUSrcB,
  input  logic            ALUM2Reg,
  input  logic            WrRegData,
  input  logic            DataMemRW,
  input  logic [1:0]      ExtSel,
  input  logic [2:0]      ALUOp,
  input  logic [1:0]      PCSrc,
  input  logic [1:0]      RegOut,
  output logic [5:0]      opcode,
  output logic            zero,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata
);

  logic [XLEN-1:0] pc, pc4, pc_next;
  logic [31:0]     ir;
  logic [XLEN-1:0] adr, bdr, aluout, dbdr;
  logic [XLEN-1:0] rf_rs, rf_rt, wb_data, ext, simm;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [4:0]      wr_reg;

  mc_regfile #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .RST (RST),
    .we  (RegWre),
    .ra1 (f_rs(ir)),
    .ra2 (f_rt(ir)),
    .wa  (wr_reg),
    .wd  (wb_data),
    .rd1 (rf_rs),
    .rd2 (rf_rt)
  );

  // Architectural and inter-stage state; the stage latches reload every cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      pc     <= RESET_PC;
      ir     <= '0;
      adr    <= '0;
      bdr    <= '0;
      aluout <= '0;
      dbdr   <= '0;
    end else begin
      if (PCWre) pc <= pc_next;
      if (IRWre) ir <= imem_rdata;
      adr    <= rf_rs;
      bdr    <= rf_rt;
      aluout <= alu_result;
      dbdr   <= dmem_rdata;
    end
  end

  // Immediate extender.
  always_comb begin
    simm = {{(XLEN-16){ir[15]}}, f_imm(ir)};
    case (ExtSel)
      EXT_SA:   ext = {{(XLEN-5){1'b0}}, f_sa(ir)};
      EXT_ZIMM: ext = {{(XLEN-16){1'b0}}, f_imm(ir)};
      default:  ext = simm;
    endcase
  end

  // ALU; shifts take the value to shift from rt (BDR) rather than rs.
  always_comb begin
    alu_a      = (ALUOp == ALU_SLL) ? bdr : adr;
    alu_b      = ALUSrcB ? ext : bdr;
    alu_result = '0;
    case (ALUOp)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_SLL: alu_result = alu_a << alu_b[4:0];
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_CMP: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  // Write-back register and data selection.
  always_comb begin
    case (RegOut)
      REGOUT_RA: wr_reg = REG_RA;
      REGOUT_RT: wr_reg = f_rt(ir);
      default:   wr_reg = f_rd(ir);
    endcase
    wb_data = WrRegData ? (ALUM2Reg ? dbdr : aluout) : pc4;
  end

  // Next-PC selection.
  always_comb begin
    pc4 = pc + XLEN'(4);
    case (PCSrc)
      PCSRC_SEQ: pc_next = pc4;
      PCSRC_BR:  pc_next = pc4 + (simm << 2);
      PCSRC_JR:  pc_next = adr;
      PCSRC_J:   pc_next = {pc4[XLEN-1:28], f_tgt(ir), 2'b00};
      default:   pc_next = pc4;
    endcase
  end

  // Outputs to the controller and the memories.
  always_comb begin
    opcode     = f_op(ir);
    zero       = (alu_result == '0);
    imem_addr  = pc;
    dmem_addr  = aluout;
    dmem_wdata = bdr;
    dmem_we    = (DataMemRW == 1'b1);
  end

endmodule
